// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: sequences sample write, FIR tap sweep, MAC pipeline drain and result handoff
module fir_mac_sequencer #(
    parameter int FIR_DEPTH   = 128,
    parameter int ADDR_WIDTH  = $clog2(FIR_DEPTH),
    parameter int RD_LATENCY  = 1,
    parameter int MAC_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_start,
    output logic                  o_ready,
    output logic                  o_sample_we,
    output logic [ADDR_WIDTH-1:0] o_sample_waddr,
    output logic [ADDR_WIDTH-1:0] o_sample_raddr,
    output logic [ADDR_WIDTH-1:0] o_coef_raddr,
    output logic                  o_mac_en,
    output logic                  o_mac_first,
    output logic                  o_result_valid,
    input  logic                  i_result_ready
);
    localparam int DRAIN_CYCLES = RD_LATENCY + MAC_LATENCY;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, WRITE, MAC, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] wptr, k;
    logic [DW-1:0] d;
    logic [RD_LATENCY-1:0] en_dl, first_dl;
    logic issue, last_tap, drain_end;
    assign issue     = state == MAC;
    assign last_tap  = k == ADDR_WIDTH'(FIR_DEPTH - 1);
    assign drain_end = d == DW'(DRAIN_CYCLES - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_start ? WRITE : IDLE;
            WRITE:   state_nx = MAC;
            MAC:     state_nx = last_tap ? DRAIN : MAC;
            DRAIN:   state_nx = drain_end ? DONE : DRAIN;
            DONE:    state_nx = i_result_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // everything, including the read-latency delay line, freezes while i_en is low
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            wptr     <= '0;
            k        <= '0;
            d        <= '0;
            en_dl    <= '0;
            first_dl <= '0;
        end else if (i_en) begin
            state    <= state_nx;
            wptr     <= (state == DONE && i_result_ready) ? wptr + 1'b1 : wptr;
            k        <= issue ? k + 1'b1 : '0;
            d        <= state == DRAIN ? d + 1'b1 : '0;
            en_dl    <= RD_LATENCY'({en_dl, issue});
            first_dl <= RD_LATENCY'({first_dl, issue && k == '0});
        end
    end
    assign o_ready        = state == IDLE && i_en;
    assign o_sample_we    = state == WRITE && i_en;
    assign o_sample_waddr = wptr;
    assign o_sample_raddr = wptr - k;
    assign o_coef_raddr   = k;
    assign o_mac_en       = en_dl[RD_LATENCY-1] && i_en;
    assign o_mac_first    = first_dl[RD_LATENCY-1] && i_en;
    assign o_result_valid = state == DONE;
endmodule
